// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM encoding, default sizing and the control-bundle presets.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DATA_STALL = 2'd1,
        BR_WAIT    = 2'd2
    } state_t;

    localparam int CNT_W_DEF     = 16;
    localparam int MAX_STALL_DEF = 8;

    // Instruction word loaded into IF/ID on a flush (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic pc_we;
        logic pc_sel_target;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET  = '{pc_we: 1'b0, pc_sel_target: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_FLOW   = '{pc_we: 1'b1, pc_sel_target: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_DSTALL = '{pc_we: 1'b0, pc_sel_target: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_BWAIT  = '{pc_we: 1'b0, pc_sel_target: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_TAKEN  = '{pc_we: 1'b1, pc_sel_target: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; clear beats increment.
// One-cycle update latency; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int             W   = 16,
    parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Turns hazard-unit stall requests and EX branch status into PC/IF-ID/ID-EX controls.
// Controls are Mealy (zero latency); counters and hazard_err update on the next edge.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_stall_req,
    input  logic             id_stall_req,
    input  logic             branch_resolved,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             pc_sel_target,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic             hazard_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);

    state_t             state;
    state_t             state_nxt;
    ctrl_t              ctrl;
    logic [RUN_W-1:0]   run_cnt;
    logic               run_clr_n;

    // DATA_STALL decodes exactly like RUN: a held data stall re-issues the
    // same bubble, and the release cycle is an ordinary RUN decode.
    always_comb begin
        ctrl      = CTRL_RESET;
        state_nxt = state;
        if (!rst_n) begin
            ctrl      = CTRL_RESET;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN, DATA_STALL: begin
                    if (id_stall_req) begin
                        ctrl      = CTRL_DSTALL;
                        state_nxt = DATA_STALL;
                    end else if (if_stall_req) begin
                        ctrl      = CTRL_BWAIT;
                        state_nxt = BR_WAIT;
                    end else begin
                        ctrl      = CTRL_FLOW;
                        state_nxt = RUN;
                    end
                end
                BR_WAIT: begin
                    if (!branch_resolved) begin
                        ctrl      = CTRL_BWAIT;
                        state_nxt = BR_WAIT;
                    end else if (branch_taken) begin
                        ctrl      = CTRL_TAKEN;
                        state_nxt = RUN;
                    end else begin
                        ctrl      = CTRL_FLOW;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    ctrl      = CTRL_RESET;
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign pc_we         = ctrl.pc_we;
    assign pc_sel_target = ctrl.pc_sel_target;
    assign ifid_we       = ctrl.ifid_we;
    assign ifid_flush    = ctrl.ifid_flush;
    assign idex_bubble   = ctrl.idex_bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (~ctrl.pc_we),
        .cnt   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (ctrl.idex_bubble),
        .cnt   (bubble_count)
    );

    // Any cycle that advances the PC ends the current stall run.
    assign run_clr_n = rst_n & ~ctrl.pc_we;

    sat_counter #(.W(RUN_W), .MAX(RUN_W'(MAX_STALL))) u_run_cnt (
        .clk   (clk),
        .clr_n (run_clr_n),
        .inc   (~ctrl.pc_we),
        .cnt   (run_cnt)
    );

    // Set on the edge where the run counter steps onto MAX_STALL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hazard_err <= 1'b0;
        end else if (!ctrl.pc_we && (run_cnt >= RUN_W'(MAX_STALL - 1))) begin
            hazard_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, corner sequences, random vs model.
module tb_pipe_ctrl;

    localparam int MAX_STALL = 8;

    logic clk = 1'b0;
    logic rst_n, if_stall_req, id_stall_req, branch_resolved, branch_taken;

    logic        pc_we, pc_sel_target, ifid_we, ifid_flush, idex_bubble, hazard_err;
    logic [15:0] stall_cycles, bubble_count;
    logic        pc_we4, pc_sel_target4, ifid_we4, ifid_flush4, idex_bubble4, hazard_err4;
    logic [3:0]  stall_cycles4, bubble_count4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16), .MAX_STALL(MAX_STALL)) u_dut (
        .clk(clk), .rst_n(rst_n), .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
        .branch_resolved(branch_resolved), .branch_taken(branch_taken),
        .pc_we(pc_we), .pc_sel_target(pc_sel_target), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .hazard_err(hazard_err)
    );

    pipe_ctrl #(.CNT_W(4), .MAX_STALL(MAX_STALL)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
        .branch_resolved(branch_resolved), .branch_taken(branch_taken),
        .pc_we(pc_we4), .pc_sel_target(pc_sel_target4), .ifid_we(ifid_we4), .ifid_flush(ifid_flush4),
        .idex_bubble(idex_bubble4), .stall_cycles(stall_cycles4), .bubble_count(bubble_count4),
        .hazard_err(hazard_err4)
    );

    // {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_bubble}
    typedef struct {
        logic       rst_n;
        logic       ifr;
        logic       idr;
        logic       res;
        logic       tk;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, let them settle.
    task automatic drive(input logic r, input logic ifr, input logic idr, input logic res, input logic tk);
        @(negedge clk);
        rst_n           = r;
        if_stall_req    = ifr;
        id_stall_req    = idr;
        branch_resolved = res;
        branch_taken    = tk;
        #1;
    endtask

    function automatic logic [4:0] ctrl16();
        return {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_bubble};
    endfunction

    function automatic logic [4:0] ctrl4();
        return {pc_we4, pc_sel_target4, ifid_we4, ifid_flush4, idex_bubble4};
    endfunction

    // Reference model: the only remembered context is "a branch is pending".
    bit m_wait;
    int m_stall, m_bub, m_stall4, m_bub4, m_run;
    bit m_err;

    function automatic logic [4:0] model_ctrl(input bit r, input bit ifr, input bit idr,
                                              input bit res, input bit tk, input bit waiting);
        if (!r)            return 5'b00011;
        if (waiting) begin
            if (!res)      return 5'b00110;
            if (tk)        return 5'b11110;
            return 5'b10100;
        end
        if (idr)           return 5'b00001;
        if (ifr)           return 5'b00110;
        return 5'b10100;
    endfunction

    task automatic model_edge(input bit r, input bit ifr, input bit idr, input logic [4:0] c);
        bit stalled;
        bit bubbled;
        stalled = !c[4];
        bubbled = c[0];
        if (!r) begin
            m_wait = 0; m_stall = 0; m_bub = 0; m_stall4 = 0; m_bub4 = 0; m_run = 0; m_err = 0;
        end else begin
            m_wait   = m_wait ? !branch_resolved : (!idr && ifr);
            m_stall  = stalled ? ((m_stall  < 65535) ? m_stall  + 1 : m_stall)  : m_stall;
            m_stall4 = stalled ? ((m_stall4 < 15)    ? m_stall4 + 1 : m_stall4) : m_stall4;
            m_bub    = bubbled ? ((m_bub    < 65535) ? m_bub    + 1 : m_bub)    : m_bub;
            m_bub4   = bubbled ? ((m_bub4   < 15)    ? m_bub4   + 1 : m_bub4)   : m_bub4;
            m_run    = stalled ? ((m_run < MAX_STALL) ? m_run + 1 : m_run) : 0;
            if (m_run >= MAX_STALL) m_err = 1;
        end
    endtask

    initial begin
        rst_n = 0; if_stall_req = 0; id_stall_req = 0; branch_resolved = 0; branch_taken = 0;

        // ---------------- directed control vectors ----------------
        tbl.push_back('{0, 1, 0, 0, 0, 5'b00011, "reset0"});
        tbl.push_back('{0, 0, 1, 1, 1, 5'b00011, "reset1"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b10100, "post_reset_run"});
        tbl.push_back('{1, 0, 1, 0, 0, 5'b00001, "dstall1"});
        tbl.push_back('{1, 0, 1, 0, 0, 5'b00001, "dstall2"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b10100, "dstall_release"});
        tbl.push_back('{1, 1, 0, 0, 0, 5'b00110, "bt_req"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b00110, "bt_wait"});
        tbl.push_back('{1, 0, 0, 1, 1, 5'b11110, "bt_taken"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b10100, "bt_back_run"});
        tbl.push_back('{1, 1, 0, 0, 0, 5'b00110, "bn_req"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b00110, "bn_wait"});
        tbl.push_back('{1, 0, 0, 1, 0, 5'b10100, "bn_not_taken"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b10100, "bn_back_run"});
        tbl.push_back('{1, 1, 0, 0, 0, 5'b00110, "bw_req"});
        tbl.push_back('{1, 0, 1, 0, 0, 5'b00110, "bw_ignore_id"});
        tbl.push_back('{1, 0, 1, 1, 1, 5'b11110, "bw_taken_with_id"});
        tbl.push_back('{1, 0, 0, 1, 1, 5'b10100, "run_ignores_resolved"});
        tbl.push_back('{1, 1, 1, 0, 0, 5'b00001, "both_req_data_first"});
        tbl.push_back('{1, 1, 1, 0, 0, 5'b00001, "both_req_hold"});
        tbl.push_back('{1, 1, 0, 0, 0, 5'b00110, "id_drop_to_brwait"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b00110, "brwait_after_dstall"});
        tbl.push_back('{1, 0, 0, 1, 0, 5'b10100, "brwait_resolve_nt"});
        tbl.push_back('{1, 0, 1, 0, 0, 5'b00001, "dstall_again"});
        tbl.push_back('{0, 0, 1, 0, 0, 5'b00011, "reset_mid_stall"});
        tbl.push_back('{1, 0, 0, 0, 0, 5'b10100, "reset_back_run"});

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].ifr, tbl[i].idr, tbl[i].res, tbl[i].tk);
            check(tbl[i].name, int'(ctrl16()), int'(tbl[i].exp));
            check({tbl[i].name, "_w4"}, int'(ctrl4()), int'(tbl[i].exp));
            if (!tbl[i].rst_n) begin
                @(negedge clk);
                #1;
                check({tbl[i].name, "_cnt_clr"}, int'(stall_cycles) + int'(bubble_count) + int'(hazard_err), 0);
            end
        end

        // ---------------- counters after a two-cycle data stall ----------------
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("rst_stall_cycles", int'(stall_cycles), 0);
        check("rst_bubble_count", int'(bubble_count), 0);
        check("rst_hazard_err", int'(hazard_err), 0);
        drive(1, 0, 0, 0, 0);
        check("first_run_pc_we", int'(pc_we), 1);
        check("first_run_ifid_we", int'(ifid_we), 1);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("ds_release_pc_we", int'(pc_we), 1);
        check("ds_stall_cycles", int'(stall_cycles), 2);
        check("ds_bubble_count", int'(bubble_count), 2);

        // ---------------- timeout and saturation ----------------
        drive(0, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            drive(1, 0, 1, 0, 0);
            check($sformatf("to_err_c%0d", c), int'(hazard_err), (c >= 9) ? 1 : 0);
        end
        drive(1, 0, 0, 0, 0);
        check("to_err_sticky", int'(hazard_err), 1);
        check("to_stall16", int'(stall_cycles), 20);
        check("to_stall4_sat", int'(stall_cycles4), 15);
        check("to_bubble4_sat", int'(bubble_count4), 15);
        check("to_err_w4", int'(hazard_err4), 1);
        drive(1, 0, 0, 0, 0);
        check("to_err_sticky2", int'(hazard_err), 1);
        check("to_stall4_hold", int'(stall_cycles4), 15);

        // ---------------- seven-cycle stall must not trip the timeout ----------------
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        check("seven_no_err", int'(hazard_err), 0);

        // ---------------- randomized against the model ----------------
        drive(0, 0, 0, 0, 0);
        m_wait = 0; m_stall = 0; m_bub = 0; m_stall4 = 0; m_bub4 = 0; m_run = 0; m_err = 0;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            logic       r, ifr, idr, res, tk;
            logic [4:0] exp;
            r   = ($urandom_range(0, 99) != 0);
            idr = ($urandom_range(0, 2) == 0);
            ifr = ($urandom_range(0, 3) == 0);
            res = ($urandom_range(0, 4) == 0);
            tk  = $urandom_range(0, 1);
            drive(r, ifr, idr, res, tk);
            exp = model_ctrl(r, ifr, idr, res, tk, m_wait);
            check("rnd_ctrl", int'(ctrl16()), int'(exp));
            check("rnd_ctrl_w4", int'(ctrl4()), int'(exp));
            check("rnd_stall_cycles", int'(stall_cycles), m_stall);
            check("rnd_bubble_count", int'(bubble_count), m_bub);
            check("rnd_stall_cycles4", int'(stall_cycles4), m_stall4);
            check("rnd_bubble_count4", int'(bubble_count4), m_bub4);
            check("rnd_hazard_err", int'(hazard_err), int'(m_err));
            model_edge(r, ifr, idr, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
